// File: rtl/uart_tx_fifo_if.sv
// Push-side and status signals of the UART transmitter, grouped for the peripheral bus.
interface uart_tx_fifo_if #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 16
);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   logic                 wr_en;
   logic [DATA_BITS-1:0] wr_data;
   logic                 full;
   logic                 empty;
   logic [CntW-1:0]      count;
   logic                 overflow;
   logic                 busy;
   logic                 UART_OUT;

   modport master (
      output wr_en, wr_data,
      input  full, empty, count, overflow, busy, UART_OUT
   );

   modport slave (
      input  wr_en, wr_data,
      output full, empty, count, overflow, busy, UART_OUT
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular FIFO; frames are sent back-to-back while data is queued.
module uart_tx_fifo #(
   parameter int unsigned CLK_DIV    = 5208,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1
) (
   input logic           sysclk,
   input logic           Reset,
   uart_tx_fifo_if.slave bus
);
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned BaudW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
   logic [CntW-1:0]      r_count;
   logic                 r_full, r_empty, r_overflow;
   state_e               r_state;
   logic [BaudW-1:0]     r_baud;
   logic [3:0]           r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity, r_tx, r_busy;

   logic                 w_push, w_pop, w_load, w_bit_end;
   logic [CntW-1:0]      w_count_d;
   logic [DATA_BITS-1:0] w_head, w_shift_d;
   state_e               w_state_d;
   logic [BaudW-1:0]     w_baud_d;
   logic [3:0]           w_bit_d;
   logic                 w_par_d, w_tx_d;

   // Full check uses the pre-edge flag, so a push is rejected even when a pop coincides.
   assign w_push    = bus.wr_en && !r_full;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_bit_end = (r_baud == BaudW'(CLK_DIV - 1));
   assign w_count_d = r_count + CntW'(w_push) - CntW'(w_pop);

   always_comb begin
      w_load    = 1'b0;
      w_state_d = r_state;
      w_baud_d  = r_baud;
      w_bit_d   = r_bit_idx;
      w_shift_d = r_shift;
      w_par_d   = r_parity;
      if (r_state != StIdle) begin
         w_baud_d = w_bit_end ? '0 : r_baud + BaudW'(1);
      end
      case (r_state)
         StIdle: begin
            w_load = !r_empty;
         end
         StStart: begin
            if (w_bit_end) begin
               w_state_d = StData;
               w_bit_d   = '0;
            end
         end
         StData: begin
            if (w_bit_end) begin
               w_shift_d = r_shift >> 1;
               if (r_bit_idx == 4'(DATA_BITS - 1)) begin
                  w_bit_d   = '0;
                  w_state_d = (PARITY != 0) ? StPar : StStop;
               end else begin
                  w_bit_d = r_bit_idx + 4'd1;
               end
            end
         end
         StPar: begin
            if (w_bit_end) begin
               w_state_d = StStop;
               w_bit_d   = '0;
            end
         end
         StStop: begin
            if (w_bit_end) begin
               if (r_bit_idx == 4'(STOP_BITS - 1)) begin
                  w_load    = !r_empty;
                  w_state_d = StIdle;
               end else begin
                  w_bit_d = r_bit_idx + 4'd1;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
      // Loading from STOP skips IDLE entirely, keeping frames back-to-back.
      if (w_load) begin
         w_state_d = StStart;
         w_shift_d = w_head;
         w_par_d   = (^w_head) ^ (PARITY == 2);
         w_baud_d  = '0;
         w_bit_d   = '0;
      end
   end

   assign w_pop = w_load;

   // Line level is decided from next-state values so UART_OUT comes straight from a flop.
   always_comb begin
      w_tx_d = 1'b1;
      case (w_state_d)
         StStart: w_tx_d = 1'b0;
         StData:  w_tx_d = w_shift_d[0];
         StPar:   w_tx_d = w_par_d;
         default: w_tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.wr_data;
      end
   end

   always_ff @(posedge sysclk) begin
      if (Reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_overflow <= 1'b0;
         r_state    <= StIdle;
         r_baud     <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         r_count    <= w_count_d;
         r_full     <= (w_count_d == CntW'(FIFO_DEPTH));
         r_empty    <= (w_count_d == '0);
         r_overflow <= r_overflow | (bus.wr_en & r_full);
         r_state    <= w_state_d;
         r_baud     <= w_baud_d;
         r_bit_idx  <= w_bit_d;
         r_shift    <= w_shift_d;
         r_parity   <= w_par_d;
         r_tx       <= w_tx_d;
         r_busy     <= (w_state_d != StIdle);
      end
   end

   assign bus.full     = r_full;
   assign bus.empty    = r_empty;
   assign bus.count    = r_count;
   assign bus.overflow = r_overflow;
   assign bus.busy     = r_busy;
   assign bus.UART_OUT = r_tx;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, parity even/odd and two stop bits.
module tb_uart_tx_fifo;
   logic sysclk = 1'b0;
   logic Reset  = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 sysclk = ~sysclk;

   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
   uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus_b ();
   uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus_c ();
   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_d ();

   uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1))
      dut_a (.sysclk(sysclk), .Reset(Reset), .bus(bus_a));
   uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1))
      dut_b (.sysclk(sysclk), .Reset(Reset), .bus(bus_b));
   uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1))
      dut_c (.sysclk(sysclk), .Reset(Reset), .bus(bus_c));
   uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2))
      dut_d (.sysclk(sysclk), .Reset(Reset), .bus(bus_d));

   // Expected line level at bit position pos of a frame (0 = start bit).
   function automatic logic frame_bit(input logic [8:0] w, input int nbits, input int par,
                                      input int pos);
      logic [8:0] mask;
      mask = (9'h1 << nbits) - 9'h1;
      if (pos == 0) return 1'b0;
      if (pos <= nbits) return w[pos-1];
      if (pos == nbits + 1 && par != 0) return (^(w & mask)) ^ (par == 2);
      return 1'b1;
   endfunction

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge sysclk);
      n_checks++;
      if (bus_a.UART_OUT !== 1'b1 || bus_a.busy !== 1'b0 || bus_a.empty !== 1'b1 ||
          bus_a.full !== 1'b0 || bus_a.count !== 3'd0 || bus_a.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a: out=%b busy=%b empty=%b full=%b count=%0d ovf=%b, want 1 0 1 0 0 0",
                  bus_a.UART_OUT, bus_a.busy, bus_a.empty, bus_a.full, bus_a.count,
                  bus_a.overflow);
      end
      n_checks++;
      if (bus_d.UART_OUT !== 1'b1 || bus_d.empty !== 1'b1 || bus_b.UART_OUT !== 1'b1 ||
          bus_c.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_others: d_out=%b d_empty=%b b_out=%b c_busy=%b, want 1 1 1 0",
                  bus_d.UART_OUT, bus_d.empty, bus_b.UART_OUT, bus_c.busy);
      end
      Reset = 1'b0;
      @(negedge sysclk);
   endtask

   task automatic test_single();
      logic exp;
      for (int t = 0; t <= 42; t++) begin
         bus_a.wr_en   = (t == 0);
         bus_a.wr_data = 8'h55;
         if (t == 1) begin
            n_checks++;
            if (bus_a.empty !== 1'b0 || bus_a.UART_OUT !== 1'b1) begin
               n_fail++;
               $display("FAIL single_latency: empty=%b out=%b, want 0 1", bus_a.empty,
                        bus_a.UART_OUT);
            end
         end
         if (t >= 2 && t < 42) begin
            exp = frame_bit(9'h055, 8, 0, (t - 2) / 4);
            n_checks++;
            if (bus_a.UART_OUT !== exp || bus_a.busy !== 1'b1) begin
               n_fail++;
               $display("FAIL single_bit t=%0d: out=%b busy=%b, want %b 1", t, bus_a.UART_OUT,
                        bus_a.busy, exp);
            end
         end
         if (t == 42) begin
            n_checks++;
            if (bus_a.busy !== 1'b0 || bus_a.UART_OUT !== 1'b1) begin
               n_fail++;
               $display("FAIL single_idle: busy=%b out=%b, want 0 1", bus_a.busy,
                        bus_a.UART_OUT);
            end
         end
         @(negedge sysclk);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [3];
      logic       exp;
      words = '{8'hA1, 8'hB2, 8'hC3};
      for (int t = 0; t <= 122; t++) begin
         bus_a.wr_en   = (t < 3);
         bus_a.wr_data = (t < 3) ? words[t] : 8'h00;
         if (t == 3) begin
            n_checks++;
            if (bus_a.count !== 3'd2 || bus_a.full !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_peak: count=%0d full=%b, want 2 0", bus_a.count, bus_a.full);
            end
         end
         if (t >= 2 && t < 122) begin
            exp = frame_bit({1'b0, words[(t - 2) / 40]}, 8, 0, ((t - 2) % 40) / 4);
            n_checks++;
            if (bus_a.UART_OUT !== exp || bus_a.busy !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_bit t=%0d: out=%b busy=%b, want %b 1", t, bus_a.UART_OUT,
                        bus_a.busy, exp);
            end
         end
         if (t == 122) begin
            n_checks++;
            if (bus_a.busy !== 1'b0 || bus_a.empty !== 1'b1 || bus_a.count !== 3'd0) begin
               n_fail++;
               $display("FAIL b2b_end: busy=%b empty=%b count=%0d, want 0 1 0", bus_a.busy,
                        bus_a.empty, bus_a.count);
            end
         end
         @(negedge sysclk);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] sent [5];
      logic [7:0] p [6];
      logic       exp;
      p    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      sent = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h44};
      for (int t = 0; t <= 202; t++) begin
         bus_a.wr_en   = (t == 0) || (t >= 3 && t <= 8);
         bus_a.wr_data = (t == 0) ? 8'h3C : ((t >= 3 && t <= 8) ? p[t - 3] : 8'h00);
         if (t == 7) begin
            n_checks++;
            if (bus_a.full !== 1'b1 || bus_a.count !== 3'd4 || bus_a.overflow !== 1'b0) begin
               n_fail++;
               $display("FAIL ovf_full: full=%b count=%0d ovf=%b, want 1 4 0", bus_a.full,
                        bus_a.count, bus_a.overflow);
            end
         end
         if (t == 9) begin
            n_checks++;
            if (bus_a.overflow !== 1'b1 || bus_a.count !== 3'd4) begin
               n_fail++;
               $display("FAIL ovf_drop: ovf=%b count=%0d, want 1 4", bus_a.overflow,
                        bus_a.count);
            end
         end
         if (t >= 2 && t < 202) begin
            exp = frame_bit({1'b0, sent[(t - 2) / 40]}, 8, 0, ((t - 2) % 40) / 4);
            n_checks++;
            if (bus_a.UART_OUT !== exp) begin
               n_fail++;
               $display("FAIL ovf_bit t=%0d: out=%b, want %b", t, bus_a.UART_OUT, exp);
            end
         end
         if (t == 202) begin
            n_checks++;
            if (bus_a.busy !== 1'b0 || bus_a.overflow !== 1'b1 || bus_a.empty !== 1'b1) begin
               n_fail++;
               $display("FAIL ovf_end: busy=%b ovf=%b empty=%b, want 0 1 1", bus_a.busy,
                        bus_a.overflow, bus_a.empty);
            end
         end
         @(negedge sysclk);
      end
   endtask

   task automatic test_parity();
      logic exp_b, exp_c;
      for (int t = 0; t <= 42; t++) begin
         bus_b.wr_en   = (t == 0);
         bus_c.wr_en   = (t == 0);
         bus_b.wr_data = 7'h07;
         bus_c.wr_data = 7'h07;
         if (t >= 2 && t < 42) begin
            exp_b = frame_bit(9'h007, 7, 1, (t - 2) / 4);
            exp_c = frame_bit(9'h007, 7, 2, (t - 2) / 4);
            n_checks++;
            if (bus_b.UART_OUT !== exp_b || bus_c.UART_OUT !== exp_c) begin
               n_fail++;
               $display("FAIL parity_bit t=%0d: even=%b odd=%b, want %b %b", t,
                        bus_b.UART_OUT, bus_c.UART_OUT, exp_b, exp_c);
            end
         end
         if (t == 34) begin
            n_checks++;
            if (bus_b.UART_OUT !== 1'b1 || bus_c.UART_OUT !== 1'b0) begin
               n_fail++;
               $display("FAIL parity_value: even=%b odd=%b, want 1 0", bus_b.UART_OUT,
                        bus_c.UART_OUT);
            end
         end
         if (t == 42) begin
            n_checks++;
            if (bus_b.busy !== 1'b0 || bus_c.busy !== 1'b0) begin
               n_fail++;
               $display("FAIL parity_len: busy_even=%b busy_odd=%b, want 0 0", bus_b.busy,
                        bus_c.busy);
            end
         end
         @(negedge sysclk);
      end
   endtask

   task automatic test_two_stop();
      logic [7:0] words [2];
      logic       exp;
      words = '{8'h00, 8'h0F};
      for (int t = 0; t <= 90; t++) begin
         bus_d.wr_en   = (t < 2);
         bus_d.wr_data = (t < 2) ? words[t] : 8'h00;
         if (t >= 2 && t < 90) begin
            exp = frame_bit({1'b0, words[(t - 2) / 44]}, 8, 0, ((t - 2) % 44) / 4);
            n_checks++;
            if (bus_d.UART_OUT !== exp || bus_d.busy !== 1'b1) begin
               n_fail++;
               $display("FAIL stop2_bit t=%0d: out=%b busy=%b, want %b 1", t, bus_d.UART_OUT,
                        bus_d.busy, exp);
            end
         end
         if (t == 90) begin
            n_checks++;
            if (bus_d.busy !== 1'b0 || bus_d.UART_OUT !== 1'b1) begin
               n_fail++;
               $display("FAIL stop2_end: busy=%b out=%b, want 0 1", bus_d.busy,
                        bus_d.UART_OUT);
            end
         end
         @(negedge sysclk);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] words [3];
      logic       exp;
      words = '{8'h5A, 8'hA5, 8'hF0};
      for (int t = 0; t <= 120; t++) begin
         bus_a.wr_en   = (t < 3);
         bus_a.wr_data = (t < 3) ? words[t] : 8'h00;
         Reset         = (t == 19);
         if (t >= 2 && t < 20) begin
            exp = frame_bit({1'b0, words[0]}, 8, 0, (t - 2) / 4);
            n_checks++;
            if (bus_a.UART_OUT !== exp) begin
               n_fail++;
               $display("FAIL rst_pre t=%0d: out=%b, want %b", t, bus_a.UART_OUT, exp);
            end
         end
         if (t == 20) begin
            n_checks++;
            if (bus_a.UART_OUT !== 1'b1 || bus_a.empty !== 1'b1 || bus_a.count !== 3'd0 ||
                bus_a.busy !== 1'b0 || bus_a.overflow !== 1'b0 || bus_a.full !== 1'b0) begin
               n_fail++;
               $display("FAIL rst_mid: out=%b empty=%b count=%0d busy=%b ovf=%b full=%b, want 1 1 0 0 0 0",
                        bus_a.UART_OUT, bus_a.empty, bus_a.count, bus_a.busy, bus_a.overflow,
                        bus_a.full);
            end
         end
         if (t > 20) begin
            n_checks++;
            if (bus_a.UART_OUT !== 1'b1 || bus_a.busy !== 1'b0) begin
               n_fail++;
               $display("FAIL rst_quiet t=%0d: out=%b busy=%b, want 1 0", t, bus_a.UART_OUT,
                        bus_a.busy);
            end
         end
         @(negedge sysclk);
      end
   endtask

   initial begin
      bus_a.wr_en = 1'b0; bus_a.wr_data = '0;
      bus_b.wr_en = 1'b0; bus_b.wr_data = '0;
      bus_c.wr_en = 1'b0; bus_c.wr_data = '0;
      bus_d.wr_en = 1'b0; bus_d.wr_data = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_parity();
      test_two_stop();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
